// File: rtl/imm_decode_stage_pkg.sv
// ============================================================================
// Module  : imm_decode_stage_pkg
// Brief   : Opcode constants, immediate format encodings and default widths
//           shared by the immediate decode stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_decode_stage_pkg;

    localparam int c_xlen_default = 32;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

endpackage

`default_nettype wire

// File: rtl/imm_decode_stage_imm_extract.sv
// ============================================================================
// Module  : imm_extract
// Brief   : Combinational RV32 immediate extraction and sign extension to XLEN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter bit EN_BJ = 1'b1
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output imm_type_e       imm_type,
    output logic            illegal
);

    // Every format is assembled as a signed 32-bit value, then widened, so
    // the XLEN=64 upper half always replicates instruction[31].
    logic signed [31:0] w_imm32;

    always_comb begin
        w_imm32  = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instruction[6:0])
            c_opc_op: begin
                imm_type = IMM_NONE;
            end
            c_opc_op_imm, c_opc_load, c_opc_jalr: begin
                w_imm32  = {{20{instruction[31]}}, instruction[31:20]};
                imm_type = IMM_I;
            end
            c_opc_store: begin
                w_imm32  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                imm_type = IMM_S;
            end
            c_opc_branch: begin
                if (EN_BJ) begin
                    w_imm32  = {{19{instruction[31]}}, instruction[31], instruction[7],
                                instruction[30:25], instruction[11:8], 1'b0};
                    imm_type = IMM_B;
                end else begin
                    illegal = 1'b1;
                end
            end
            c_opc_lui, c_opc_auipc: begin
                w_imm32  = {instruction[31:12], 12'b0};
                imm_type = IMM_U;
            end
            c_opc_jal: begin
                if (EN_BJ) begin
                    w_imm32  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                instruction[20], instruction[30:21], 1'b0};
                    imm_type = IMM_J;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign immediate = XLEN'(w_imm32);

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// ============================================================================
// Module  : imm_decode_stage
// Brief   : Immediate decode pipeline stage with a DEPTH-entry circular FIFO
//           and registered head outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int DEPTH = 2,
    parameter bit EN_BJ = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_type,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [XLEN-1:0] w_imm;
    imm_type_e       w_type;
    logic            w_illegal;

    imm_extract #(
        .XLEN  (XLEN),
        .EN_BJ (EN_BJ)
    ) u_extract (
        .instruction (instruction),
        .immediate   (w_imm),
        .imm_type    (w_type),
        .illegal     (w_illegal)
    );

    logic [XLEN-1:0]    r_mem_imm   [DEPTH];
    logic [2:0]         r_mem_type  [DEPTH];
    logic               r_mem_ill   [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic [XLEN-1:0]    r_mem_pc    [DEPTH];

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [XLEN-1:0]    r_immediate;
    logic [2:0]         r_imm_type;
    logic               r_illegal;
    logic [31:0]        r_instr_out;
    logic [XLEN-1:0]    r_pc_out;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    logic               w_enq;
    logic               w_deq;
    logic [c_ptr_w-1:0] w_rd_next;
    logic               w_remain_empty;

    assign in_ready       = (r_count < c_cnt_w'(DEPTH));
    assign out_valid      = (r_count != '0);
    assign w_enq          = in_valid && in_ready && !flush;
    assign w_deq          = out_valid && out_ready;
    assign w_rd_next      = w_deq ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_remain_empty = (r_count == c_cnt_w'(w_deq));

    // The head view is registered: it preloads the entry that will sit at
    // the read pointer after this edge, bypassing the incoming word when the
    // buffer would otherwise be empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_immediate <= '0;
            r_imm_type  <= '0;
            r_illegal   <= 1'b0;
            r_instr_out <= '0;
            r_pc_out    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem_imm[r_wr_ptr]   <= w_imm;
                r_mem_type[r_wr_ptr]  <= w_type;
                r_mem_ill[r_wr_ptr]   <= w_illegal;
                r_mem_instr[r_wr_ptr] <= instruction;
                r_mem_pc[r_wr_ptr]    <= pc_in;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_deq);
            if (w_remain_empty) begin
                if (w_enq) begin
                    r_immediate <= w_imm;
                    r_imm_type  <= w_type;
                    r_illegal   <= w_illegal;
                    r_instr_out <= instruction;
                    r_pc_out    <= pc_in;
                end
            end else begin
                r_immediate <= r_mem_imm[w_rd_next];
                r_imm_type  <= r_mem_type[w_rd_next];
                r_illegal   <= r_mem_ill[w_rd_next];
                r_instr_out <= r_mem_instr[w_rd_next];
                r_pc_out    <= r_mem_pc[w_rd_next];
            end
        end
    end

    assign immediate = r_immediate;
    assign imm_type  = r_imm_type;
    assign illegal   = r_illegal;
    assign instr_out = r_instr_out;
    assign pc_out    = r_pc_out;

endmodule

`default_nettype wire

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of immediate and PC (legal values 32, 64).
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries (legal 1..4).
REQ-003 SHALL have parameter EN_BJ, default 1, enables B-type and J-type decoding (0 = treated as unsupported).
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 flush  in  1  discard all buffered entries (branch mispredict).
REQ-008 in_valid  in  1  upstream instruction valid.
REQ-009 in_ready  out  1  stage can accept; equals (count < DEPTH).
REQ-010 instruction  in  32  raw RV32 instruction word.
REQ-011 pc_in  in  XLEN  PC of instruction.
REQ-012 out_valid  out  1  head entry valid; equals (count != 0).
REQ-013 out_ready  in  1  downstream accepts head.
REQ-014 immediate  out  XLEN  decoded, sign-extended immediate of head.
REQ-015 imm_type  out  3  format of head: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-016 instr_out, pc_out  out  32, XLEN  head instruction and PC passthrough.
REQ-017 illegal  out  1  head opcode unsupported.

Function
REQ-018 Opcode decode SHALL be: 0110011 R -> imm 0; 0010011, 0000011, 1100111 -> I {sext inst[31:20]}; 0100011 -> S {sext inst[31:25],inst[11:7]}; 1100011 -> B {sext inst[31],inst[7],inst[30:25],inst[11:8],0}; 0110111, 0010111 -> U {inst[31:12],12'b0}; 1101111 -> J {sext inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-019 All immediates SHALL be sign-extended from inst[31] to XLEN; U-type upper bits above 31 replicate inst[31] when XLEN=64.
REQ-020 Any other opcode, or B/J with EN_BJ=0, SHALL yield immediate 0, imm_type 0, illegal 1; entry still flows through.
REQ-021 Decoding SHALL occur at enqueue; stored entry = {immediate, imm_type, illegal, instruction, pc_in}.
REQ-022 Enqueue SHALL occur when in_valid && in_ready && !flush; dequeue when out_valid && out_ready.
REQ-023 Latency SHALL be exactly 1 cycle: entry accepted at edge N is visible on outputs after edge N with out_valid=1.
REQ-024 Buffer SHALL be FIFO-ordered circular, DEPTH entries, read/write pointers wrapping at DEPTH-1 -> 0.
REQ-025 Simultaneous enqueue and dequeue SHALL keep count unchanged, including when count==DEPTH (in_ready=0 then blocks enqueue; dequeue only).
REQ-026 Full: in_ready=0; an in_valid held high SHALL not be lost and SHALL enqueue on the cycle after a dequeue frees a slot.
REQ-027 Empty: out_valid=0; outputs SHALL hold last values but are don't-care.
REQ-028 Outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 flush SHALL, at the next edge, set count=0 and both pointers=0; concurrent enqueue and dequeue in that cycle are ignored.
REQ-030 in_ready and out_valid SHALL be driven from registered count only (no combinational path from out_ready).

Reset
REQ-031 On rst at an edge: count=0, pointers=0, out_valid=0, in_ready=1, immediate=0, imm_type=0, illegal=0, instr_out=0, pc_out=0.
REQ-032 rst SHALL take priority over flush, enqueue and dequeue; in-flight entries are discarded.

Structure
REQ-033 Shared package SHALL hold opcode constants, imm_type encodings (0-5) and XLEN default.
REQ-034 Combinational decode SHALL be a sub-module imm_extract (instruction, XLEN param -> immediate, imm_type, illegal); buffer control stays in imm_decode_stage.

Verification
REQ-035 Enqueue 0xFFF00093 (addi, imm -1), out_ready=1 -> next cycle immediate=0xFFFFFFFF, imm_type=1, illegal=0.
REQ-036 Enqueue B-type 0xFE000EE3 (beq, offset -4) EN_BJ=1 -> immediate=0xFFFFFFFC, imm_type=3; same with EN_BJ=0 -> immediate=0, illegal=1.
REQ-037 XLEN=64, LUI 0x800002B7 -> immediate=0xFFFFFFFF80000000, imm_type=4.
REQ-038 DEPTH=2, out_ready=0, three back-to-back valids -> in_ready=0 after two; release out_ready -> all three emerge in order, third not lost.
REQ-039 Full buffer with flush and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, no entry enqueued; rst mid-stream -> all outputs 0 next cycle.
